reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  Reads the register file's debug port (reg_no -> val) by walking the register indices in order.
//  Emits each register as one beat on a valid/ready stream toward the debug/trace logic.
//  Provides the reader side of the register file's inspection port, so a bench or debug host can snapshot architectural state.
// PARAMETERS
//  DATA_W     32  width of a register word / val
//  IDX_W      5   width of reg_no / register index
//  NUM_REGS   32  registers walked per dump (1..2**IDX_W)
//  SKIP_ZERO  0   1: start the walk at index 1 (r0 is hardwired zero)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       1-cycle request; begins a dump when idle
//  reg_no     out  IDX_W   index driven to the register file debug port
//  val        in   DATA_W  register file debug read data (combinational from reg_no)
//  out_valid  out  1       stream beat valid
//  out_ready  in   1       stream sink ready
//  out_data   out  DATA_W  register value
//  out_idx    out  IDX_W   index of out_data
//  out_last   out  1       final beat of the dump
//  busy       out  1       dump in progress (state != IDLE)
//  done       out  1       1-cycle pulse after the last beat handshakes
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (rst).
//  Reset: all outputs 0; reg_no=0; state=IDLE.
//  FSM: IDLE -> ADDR -> CAPT -> SEND -> (ADDR | FIN) -> IDLE.
//  - IDLE: on start, set reg_no to the first index (SKIP_ZERO?1:0), busy=1, go to ADDR.
//  - ADDR: reg_no is stable for one full cycle; go to CAPT.
//  - CAPT: register val into out_data and reg_no into out_idx; out_valid=1.
//    out_last = (reg_no == NUM_REGS-1). Go to SEND.
//  - SEND: hold out_data, out_idx and out_last stable until out_valid && out_ready.
//    On handshake: out_valid=0. If not last, reg_no+1 and go to ADDR; else go to FIN.
//  - FIN: done=1 for exactly one cycle, busy=0 on the next cycle, go to IDLE.
//  Latency: start -> first out_valid is 2 cycles. With out_ready held at 1, one beat every 3 cycles.
//  A non-first dump (SKIP_ZERO=1) has NUM_REGS-1 beats.
//  start while busy is ignored; there is no queuing.
//  out_ready is don't-care while out_valid=0; out_valid never drops without a handshake.
//  Backpressure may stall the dump indefinitely.
//  reg_no never exceeds NUM_REGS-1. The increment is compared before it wraps, so NUM_REGS=2**IDX_W does not overflow.
//  rst mid-dump: the FSM aborts to IDLE next edge, the beat is dropped, and no done pulse is issued.
//  start and rst in the same cycle: rst wins.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined:
//  - A DATA_W XOR accumulator clears on start and absorbs each out_data on its handshake.
//  - After the last register beat, one extra beat is sent with out_data=XOR and out_idx=0.
//  - out_last moves to that checksum beat; done follows its handshake.
//  DUMP_CHECKSUM_EN undefined: no accumulator, no extra beat, out_last is on the final register.
// STRUCTURE
//  Shared package (pipeline pkg): localparams for the FSM state encoding (IDLE, ADDR, CAPT, SEND, FIN; plus CSUM when the macro is set).
//  The same pkg holds DATA_W and IDX_W defaults shared with the register file.
//  Sub-module: dump_index_counter (load-first / increment / is_last compare).
//  Everything else is inline.
// TESTING
//  1. Reset, preload r1=A5A5A5A5 and r2=A5A5A5A6, start with out_ready=1.
//     Expect 32 beats with idx 0..31, beat 1 = A5A5A5A5, beat 2 = A5A5A5A6, out_last only on idx 31, done 1 cycle later.
//  2. SKIP_ZERO=1: first beat idx=1, 31 beats total, out_last on idx 31.
//  3. Toggle out_ready 1/0 every 2 cycles: the data/idx sequence matches test 1.
//     out_data is stable while out_valid && !out_ready.
//  4. Pulse start again at the 5th beat: it is ignored, and the dump finishes with exactly 32 beats and one done.
//  5. Assert rst at beat 10 (idx 9): next cycle out_valid=0, busy=0, reg_no=0, no done.
//     A following start restarts from idx 0.
//  6. DUMP_CHECKSUM_EN with all regs 0 except r1 and r2 as in test 1.
//     Expect 33 beats; the last has data 00000003 and idx 0 with out_last=1.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// ---------------------------------------------------------------------------
// reg_dump_reader_pkg
//   Shared definitions for the register-dump reader and the register file it
//   inspects: default word/index widths and the reader FSM state encoding.
//   Optional feature macro: DUMP_CHECKSUM_EN adds the CSUM state.
// ---------------------------------------------------------------------------
package reg_dump_reader_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_CAPT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd5;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_ADDR = S_ADDR,
    ST_CAPT = S_CAPT,
    ST_SEND = S_SEND,
`ifdef DUMP_CHECKSUM_EN
    ST_CSUM = S_CSUM,
`endif
    ST_FIN  = S_FIN
  } state_t;

endpackage

// File: rtl/reg_dump_reader_dump_index_counter.sv
// ---------------------------------------------------------------------------
// reg_dump_reader_dump_index_counter
//   Register index walker for the dump reader. Loads the first index, steps
//   by one on request, and flags the final index.
//   Ports:
//     clk, rst    clock, synchronous active-high reset (index -> 0)
//     i_load      load the first index (1 when SKIP_ZERO, else 0)
//     i_inc       advance to the next index
//     o_idx       current register index
//     o_is_last   o_idx == NUM_REGS-1
// ---------------------------------------------------------------------------
module reg_dump_reader_dump_index_counter #(
  parameter int IDX_W     = 5,
  parameter int NUM_REGS  = 32,
  parameter int SKIP_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_is_last
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'((SKIP_ZERO != 0) ? 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);

  logic [IDX_W-1:0] r_idx;
  logic             w_is_last;

  assign w_is_last = (r_idx == LAST_IDX);

  // The last-index compare gates the increment, so the index never wraps even
  // when NUM_REGS fills the whole index space.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_load) begin
      r_idx <= FIRST_IDX;
    end else if (i_inc && !w_is_last) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_idx     = r_idx;
  assign o_is_last = w_is_last;

endmodule

// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
//   Walks the register file's debug read port (reg_no -> val) in index order
//   and emits one valid/ready beat per register toward debug/trace logic.
//   Optional feature macro: DUMP_CHECKSUM_EN -- appends one beat carrying the
//   XOR of all dumped words (out_idx=0), which then carries out_last.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     start              one-cycle dump request, ignored while busy
//     reg_no / val       register file debug port (val combinational)
//     out_valid/ready    stream handshake
//     out_data/out_idx   register word and its index
//     out_last           final beat of the dump
//     busy               dump in progress
//     done               one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int NUM_REGS  = 32,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  reg_no,
  input  logic [DATA_W-1:0] val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_idx;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  logic w_hs;
  logic w_load;
  logic w_inc;
  logic w_is_last;

  assign w_hs   = r_valid && out_ready;
  assign w_load = (r_state == ST_IDLE) && start;
  assign w_inc  = (r_state == ST_SEND) && w_hs && !w_is_last;

  reg_dump_reader_dump_index_counter #(
    .IDX_W     (IDX_W),
    .NUM_REGS  (NUM_REGS),
    .SKIP_ZERO (SKIP_ZERO)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_inc     (w_inc),
    .o_idx     (reg_no),
    .o_is_last (w_is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_state <= ST_ADDR;
`ifdef DUMP_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        // reg_no was updated last edge; give the register file a full cycle.
        ST_ADDR: r_state <= ST_CAPT;
        ST_CAPT: begin
          r_data  <= val;
          r_idx   <= reg_no;
          r_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          r_last  <= 1'b0;
`else
          r_last  <= w_is_last;
`endif
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_hs) begin
            if (!w_is_last) begin
              r_valid <= 1'b0;
              r_state <= ST_ADDR;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              // Fold in the final word and present the checksum beat directly;
              // out_valid stays high because a new beat replaces the old one.
              r_csum  <= r_csum ^ r_data;
              r_data  <= r_csum ^ r_data;
              r_idx   <= '0;
              r_last  <= 1'b1;
              r_state <= ST_CSUM;
`else
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FIN;
`endif
            end
`ifdef DUMP_CHECKSUM_EN
            if (!w_is_last) begin
              r_csum <= r_csum ^ r_data;
            end
`endif
          end
        end
`ifdef DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end
        end
`endif
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_reader
//   Directed bench for reg_dump_reader. Two instances share clock, start,
//   rst and out_ready: u_dut_a walks from r0, u_dut_b has SKIP_ZERO=1.
//   Build with +define+DUMP_CHECKSUM_EN to check the checksum beat.
// ---------------------------------------------------------------------------
module tb_reg_dump_reader;

`ifdef DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;
  logic out_ready;
  logic [31:0] regs [32];

  logic [4:0]  a_reg_no, a_idx, b_reg_no, b_idx;
  logic [31:0] a_val, a_data, b_val, b_data;
  logic        a_valid, a_last, a_busy, a_done;
  logic        b_valid, b_last, b_busy, b_done;

  assign a_val = regs[a_reg_no];
  assign b_val = regs[b_reg_no];

  reg_dump_reader #(.DATA_W(32), .IDX_W(5), .NUM_REGS(32), .SKIP_ZERO(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .reg_no(a_reg_no), .val(a_val),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_idx(a_idx),
    .out_last(a_last), .busy(a_busy), .done(a_done)
  );

  reg_dump_reader #(.DATA_W(32), .IDX_W(5), .NUM_REGS(32), .SKIP_ZERO(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .reg_no(b_reg_no), .val(b_val),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_idx(b_idx),
    .out_last(b_last), .busy(b_busy), .done(b_done)
  );

  // Monitored instance select
  logic        sel;
  logic        m_valid, m_last, m_busy, m_done;
  logic [31:0] m_data;
  logic [4:0]  m_idx;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_last  = sel ? b_last  : a_last;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_data  = sel ? b_data  : a_data;
  assign m_idx   = sel ? b_idx   : a_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] cap_data [64];
  logic [4:0]  cap_idx  [64];
  logic        cap_last [64];
  int          hs_cyc   [64];
  int nb, nd, lat, done_cyc, idle_cyc, unstable;
  logic rst_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Starts a dump and records every handshaked beat of the monitored instance.
  // rmode 0: ready held high; 1: ready toggles every 2 cycles.
  task automatic run_dump(input int rmode, input int restart_beat, input int rst_beat);
    int cyc;
    logic hold, pl, restarted, fin;
    logic [31:0] pd;
    logic [4:0] pi;
    nb = 0; nd = 0; lat = -1; done_cyc = -1; idle_cyc = -1; unstable = 0; rst_hit = 1'b0;
    hold = 1'b0; pl = 1'b0; pd = '0; pi = '0; restarted = 1'b0; fin = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!fin && cyc < 3000) begin
      if (m_valid && lat < 0) lat = cyc;
      if (m_done) begin
        nd++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (hold && (!m_valid || m_data !== pd || m_idx !== pi || m_last !== pl)) unstable++;
      if (!m_busy && idle_cyc < 0) idle_cyc = cyc;
      out_ready = (rmode == 0) ? 1'b1 : (((cyc / 2) % 2) == 0);
      start = 1'b0;
      if (restart_beat >= 0 && !restarted && m_valid && nb == restart_beat) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (rst_beat >= 0 && m_valid && nb == rst_beat) begin
        rst = 1'b1;
        out_ready = 1'b0;
        rst_hit = 1'b1;
        fin = 1'b1;
      end
      if (m_valid && out_ready && nb < 64) begin
        cap_data[nb] = m_data;
        cap_idx[nb]  = m_idx;
        cap_last[nb] = m_last;
        hs_cyc[nb]   = cyc;
        nb++;
      end
      hold = m_valid && !out_ready;
      pd = m_data; pi = m_idx; pl = m_last;
      if (idle_cyc >= 0 && cyc >= idle_cyc + 3) fin = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!fin) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic settle();
    int k;
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    k = 0;
    while ((a_busy || b_busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("settle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_dump(input string t, input int first);
    int nreg, bad, lasts, li;
    logic [31:0] csum;
    nreg = 32 - first;
    bad = 0; lasts = 0; csum = '0;
    li = (nb > 0) ? nb - 1 : 0;
    check({t, "_beats"}, nb, nreg + CS);
    for (int i = 0; i < nreg && i < nb; i++) begin
      if (cap_idx[i] !== 5'(first + i)) bad++;
      if (cap_data[i] !== regs[first + i]) bad++;
      csum = csum ^ regs[first + i];
    end
    for (int i = 0; i < nb; i++) if (cap_last[i]) lasts++;
    check({t, "_seq"}, bad, 0);
    check({t, "_nlast"}, lasts, 1);
    check({t, "_last_pos"}, 32'(cap_last[li]), 1);
    check({t, "_done_cnt"}, nd, 1);
    check({t, "_done_time"}, done_cyc, hs_cyc[li] + 1);
    check({t, "_busy_drop"}, idle_cyc, done_cyc + 1);
    check({t, "_stable"}, unstable, 0);
`ifdef DUMP_CHECKSUM_EN
    check({t, "_csum_data"}, cap_data[li], csum);
    check({t, "_csum_idx"}, 32'(cap_idx[li]), 0);
    check({t, "_csum_hand"}, csum, 32'h0000_0003);
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1] = 32'hA5A5_A5A5;
    regs[2] = 32'hA5A5_A5A6;
    sel = 1'b0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid", 32'(a_valid), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_last", 32'(a_last), 0);
    check("rst_reg_no", 32'(a_reg_no), 0);
    check("rst_data", a_data, 0);
    check("rst_idx", 32'(a_idx), 0);
    check("rst_b_reg_no", 32'(b_reg_no), 0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: full dump, ready held high
    sel = 1'b0;
    run_dump(0, -1, -1);
    check_dump("t1", 0);
    check("t1_latency", lat, 2);
    check("t1_beat1", cap_data[1], 32'hA5A5_A5A5);
    check("t1_beat2", cap_data[2], 32'hA5A5_A5A6);
    check("t1_beat0", cap_data[0], 32'h0);
    check("t1_last_idx", 32'(cap_idx[31]), 31);
    check("t1_spacing", hs_cyc[1] - hs_cyc[0], 3);
    settle();

    // Test 2: SKIP_ZERO instance
    sel = 1'b1;
    run_dump(0, -1, -1);
    check_dump("t2", 1);
    check("t2_first_idx", 32'(cap_idx[0]), 1);
    check("t2_first_data", cap_data[0], 32'hA5A5_A5A5);
    settle();

    // Test 3: backpressure, ready toggles every 2 cycles
    sel = 1'b0;
    run_dump(1, -1, -1);
    check_dump("t3", 0);
    settle();

    // Test 4: start pulsed again during the 5th beat is ignored
    run_dump(0, 4, -1);
    check_dump("t4", 0);
    settle();

    // Test 5: reset during beat 10 (idx 9) aborts the dump
    run_dump(0, -1, 9);
    check("t5_rst_hit", 32'(rst_hit), 1);
    check("t5_beats_before", nb, 9);
    check("t5_valid", 32'(a_valid), 0);
    check("t5_busy", 32'(a_busy), 0);
    check("t5_reg_no", 32'(a_reg_no), 0);
    check("t5_done", 32'(a_done), 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_done_after", 32'(a_done), 0);
    check("t5_busy_after", 32'(a_busy), 0);
    settle();
    run_dump(0, -1, -1);
    check("t5r_first_idx", 32'(cap_idx[0]), 0);
    check_dump("t5r", 0);
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
